// File: rtl/character_buffer_registerfile_pkg.sv
// Shared widths and types for the keyboard character buffer storage.
package char_buffer_pkg;

  localparam int CB_DATA_WIDTH = 8;
  localparam int CB_ADDR_WIDTH = 5;
  localparam int CB_DEPTH      = 32;

  typedef logic [CB_DATA_WIDTH-1:0] cb_char_t;
  typedef logic [CB_ADDR_WIDTH-1:0] cb_addr_t;

endpackage

// File: rtl/character_buffer_registerfile_entry.sv
// One storage byte: async-clear register with a local write enable; no backpressure.
module character_buffer_entry
  import char_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = CB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else if (enable) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/character_buffer_registerfile.sv
// 32x8 character FIFO storage: one clocked write port, two zero-latency read ports.
// Writes land on the rising clk edge; reads are combinational with no write bypass.
module character_buffer_registerfile
  import char_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = CB_DATA_WIDTH,
  parameter int ADDR_WIDTH = CB_ADDR_WIDTH,
  parameter int DEPTH      = CB_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] select_a,
  input  logic [ADDR_WIDTH-1:0] select_b,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b
);

  logic [DATA_WIDTH-1:0] entries [DEPTH];

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_entry
      character_buffer_entry #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_entry (
        .clk      (clk),
        .reset    (reset),
        .enable   (write && (address == ADDR_WIDTH'(i))),
        .data_in  (data_in),
        .data_out (entries[i])
      );
    end
  endgenerate

  // DEPTH == 2**ADDR_WIDTH, so every select value hits a real entry.
  assign out_a = entries[select_a];
  assign out_b = entries[select_b];

endmodule

// File: tb/tb_character_buffer_registerfile.sv
// Randomized scoreboard bench for the character buffer register file.
module tb_character_buffer_registerfile;

  logic       clk = 1'b0;
  logic       reset;
  logic       write;
  logic [4:0] address;
  logic [7:0] data_in;
  logic [4:0] select_a;
  logic [4:0] select_b;
  logic [7:0] out_a;
  logic [7:0] out_b;

  character_buffer_registerfile dut (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .address  (address),
    .data_in  (data_in),
    .select_a (select_a),
    .select_b (select_b),
    .out_a    (out_a),
    .out_b    (out_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] mem [32];
  int         checks = 0;
  int         failures = 0;
  event       sample_ev;

  // Monitor: samples the read ports 1ns after each request and scores them.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: got a=%02h b=%02h, expected a queued entry", out_a, out_b);
      end else begin
        e = sb_q.pop_front();
        if (out_a !== e.exp_a) begin
          failures++;
          $display("FAIL %s port_a: got %02h, expected %02h (sel=%0d)", e.name, out_a, e.exp_a, select_a);
        end
        checks++;
        if (out_b !== e.exp_b) begin
          failures++;
          $display("FAIL %s port_b: got %02h, expected %02h (sel=%0d)", e.name, out_b, e.exp_b, select_b);
        end
      end
    end
  end

  task automatic chk(input string name);
    exp_t e;
    e.name  = name;
    e.exp_a = mem[select_a];
    e.exp_b = mem[select_b];
    sb_q.push_back(e);
    -> sample_ev;
    #2;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) mem[k] = 8'h00;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    write = 1'b1; address = a; data_in = d;
    @(posedge clk);
    mem[a] = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; address = '0; data_in = '0;
    select_a = '0; select_b = '0;
    clear_model();
    #12;
    chk("reset_state");
    reset = 1'b0;

    // Write disable leaves entry 7 untouched.
    @(negedge clk);
    write = 1'b0; address = 5'd7; data_in = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    select_a = 5'd7; select_b = 5'd7;
    chk("write_disable");

    // Basic write/read.
    wr(5'd3, 8'h1C);
    wr(5'd31, 8'h32);
    select_a = 5'd3; select_b = 5'd31;
    chk("basic_rw");
    if (mem[3] != 8'h1C || mem[31] != 8'h32) $display("model setup error");

    // Read-during-write: old value before the edge, new value after it.
    wr(5'd5, 8'hAA);
    @(negedge clk);
    select_a = 5'd5; select_b = 5'd5;
    write = 1'b1; address = 5'd5; data_in = 8'h55;
    chk("rdw_before_edge");
    @(posedge clk);
    mem[5] = 8'h55;
    chk("rdw_after_edge");
    @(negedge clk);
    write = 1'b0;

    // Pattern fill, same-entry sweep, then opposing sweep.
    for (int i = 0; i < 32; i++) wr(5'(i), 8'(i) ^ 8'hA5);
    for (int i = 0; i < 32; i++) begin
      select_a = 5'(i); select_b = 5'(i);
      chk("sweep_same");
    end
    for (int i = 0; i < 32; i++) begin
      select_a = 5'(i); select_b = 5'(31 - i);
      chk("sweep_opposite");
    end

    // Reset clear: random fill, then async reset between edges.
    for (int i = 0; i < 32; i++) wr(5'(i), 8'($urandom_range(1, 255)));
    @(negedge clk);
    #1;
    reset = 1'b1;
    clear_model();
    for (int i = 0; i < 32; i++) begin
      select_a = 5'(i); select_b = 5'(31 - i);
      chk("async_reset_clear");
    end
    @(negedge clk);
    reset = 1'b0;

    // Reset coinciding with a write edge wins.
    @(negedge clk);
    write = 1'b1; address = 5'd10; data_in = 8'h77;
    @(posedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    write = 1'b0;
    clear_model();
    select_a = 5'd10; select_b = 5'd10;
    chk("reset_write_race");
    wr(5'd10, 8'h77);
    select_a = 5'd10; select_b = 5'd0;
    chk("write_after_reset");

    // Randomized traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      logic we;
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      write = we;
      address = 5'($urandom);
      data_in = 8'($urandom);
      select_a = 5'($urandom);
      select_b = ($urandom_range(0, 3) == 0) ? address : 5'($urandom);
      chk("rand_pre_edge");
      @(posedge clk);
      if (we) mem[address] = data_in;
      chk("rand_post_edge");
    end
    @(negedge clk);
    write = 1'b0;

    #10;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/character_buffer_registerfile.md
Name: character_buffer_registerfile

Overview:
- 32-entry x 8-bit storage array for the keyboard character FIFO.
- One synchronous write port and two independent combinational read ports.
- The surrounding buffer controller owns head/tail pointers:
  - writes each received PS/2 scan byte at the tail address;
  - reads the head entry on port A and the tail entry on port B.

Parameters:
- DATA_WIDTH, 8, bits per entry.
- ADDR_WIDTH, 5, address/select width.
- DEPTH, 32, number of entries; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-high; clears every entry.
- write  input  1  write enable, sampled on rising clk.
- address  input  ADDR_WIDTH  write address.
- data_in  input  DATA_WIDTH  write data.
- select_a  input  ADDR_WIDTH  read address, port A.
- select_b  input  ADDR_WIDTH  read address, port B.
- out_a  output  DATA_WIDTH  contents of entry select_a.
- out_b  output  DATA_WIDTH  contents of entry select_b.

Behaviour:
- Storage: DEPTH registers of DATA_WIDTH bits, indexed 0..DEPTH-1.
- Reset:
  - When reset goes high, all entries go to 0 immediately, without waiting for clk.
  - While reset is high, entries stay 0 and write is ignored.
  - out_a and out_b therefore read 0 during and right after reset.
- Write:
  - On a rising clk with reset low and write=1, entry[address] <= data_in.
  - All other entries hold.
  - With write=0, no entry changes.
- Read:
  - out_a = entry[select_a] and out_b = entry[select_b], purely combinational, zero-cycle latency.
  - Read ports are not registered.
- Read-during-write to the same address: there is no bypass.
  - Before the clock edge the output shows the old value.
  - After the edge it shows the new value, within the same cycle as the edge.
- Both read ports may select the same entry; both show identical data.
- Addresses are full-range (5 bits, 32 entries); there is no out-of-range case.
  - Wrap-around of head/tail pointers is the controller's job.
- Reset mid-operation: an asynchronous reset that coincides with a write edge wins, and the entry is 0.
- A write in the first clk edge after reset deasserts takes effect normally.
- No X propagation: every entry is defined from reset onward.
- Without reset, the power-up contents are don't-care; the bench must apply reset first.

Decomposition:
- Shared package char_buffer_pkg:
  - CB_DATA_WIDTH = 8;
  - CB_ADDR_WIDTH = 5;
  - CB_DEPTH = 32;
  - typedef cb_char_t (DATA_WIDTH-bit logic);
  - typedef cb_addr_t (ADDR_WIDTH-bit logic).
- One natural sub-module, character_buffer_entry:
  - a single DATA_WIDTH register with async reset and a local enable;
  - the enable is driven by the decoded (write && address == i);
  - instantiated DEPTH times through a generate loop.
- Read muxes are two DEPTH:1 combinational selects in the top module.

Test Plan:
- Reset clear: load random data into all 32 entries, pulse reset between clock edges -> out_a and out_b read 0x00 for every select value 0..31, with no clk edge needed.
- Basic write/read: write 0x1C to address 3 and 0x32 to address 31, then set select_a=3, select_b=31 -> out_a=0x1C, out_b=0x32.
- Write disable: write=0 with address=7, data_in=0xFF, one clock -> entry 7 still reads 0x00.
- Read-during-write: entry 5=0xAA, select_a=5, write 0x55 to 5 -> out_a=0xAA before the edge, 0x55 after it.
- Dual-port same entry and full sweep:
  - write the value (i XOR 0xA5) to each address i;
  - set select_a = select_b = i for all i -> both outputs = i XOR 0xA5;
  - then set select_a=i, select_b=31-i -> out_a = i XOR 0xA5 and out_b = (31-i) XOR 0xA5, independently.
- Reset vs write race: assert reset coincident with a write of 0x77 to address 10 -> entry 10 reads 0x00; the first write after deassert lands normally.
